ex_mem: RTL and testbench

Pipeline register between the execute stage and the memory-access stage of the five-stage core. Each cycle it captures the execute result: writeback target, ALU data, HI/LO update, aluop, and load/store address and data. It presents these to the memory stage on the following cycle. It honours the global stall vector and the exception flush. It also holds the 64-bit partial product and cycle counter that the execute stage feeds back to itself for two-cycle multiply-accumulate (madd/maddu/msub/msubu).

---
 rtl/ex_mem_pkg.sv | 37 +++
 rtl/ex_mem.sv | 92 +++++++++
 tb/tb_ex_mem.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared widths and constants for the EX/MEM pipeline register.
// Also holds the decode of the global stall vector for this stage boundary.
package ex_mem_pkg;

  localparam int REG_BUS        = 32;
  localparam int REG_ADDR_BUS   = 5;
  localparam int ALU_OP_BUS     = 8;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int STALL_BUS      = 6;

  localparam logic [REG_BUS-1:0]        ZERO_WORD   = '0;
  localparam logic [DOUBLE_REG_BUS-1:0] ZERO_DWORD  = '0;
  localparam logic                      RST_ENABLE  = 1'b1;
  localparam logic [ALU_OP_BUS-1:0]     EXE_NOP_OP  = 8'h00;

  // Bit positions in the global stall vector
  localparam int EX_STALL  = 3;
  localparam int MEM_STALL = 4;

  // What the EX/MEM register does on an edge, given the stall vector.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,  // execute running: capture ex_* into mem_*
    ACT_BUBBLE  = 2'd1,  // execute stalled, memory running: insert NOP
    ACT_HOLD    = 2'd2   // both stalled: keep everything
  } stage_act_e;

  // Stall decode. The stall controller never raises MEM without EX;
  // if it ever did, execute is not stalled, so the register advances.
  function automatic stage_act_e stage_act(input logic [STALL_BUS-1:0] stall);
    stage_act_e act;
    if (!stall[EX_STALL])      act = ACT_ADVANCE;
    else if (!stall[MEM_STALL]) act = ACT_BUBBLE;
    else                        act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register. Carries the execute result to the memory
// stage one cycle later and keeps the multiply-accumulate partial product
// and cycle count alive across an execute-only stall so execute can finish
// madd/maddu/msub/msubu on the second cycle. Every output is a flop.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [STALL_BUS-1:0]      stall,
  input  logic                      flush,
  input  logic [REG_ADDR_BUS-1:0]   ex_wd,
  input  logic                      ex_wreg,
  input  logic [REG_BUS-1:0]        ex_wdata,
  input  logic                      ex_whilo,
  input  logic [REG_BUS-1:0]        ex_hi,
  input  logic [REG_BUS-1:0]        ex_lo,
  input  logic [ALU_OP_BUS-1:0]     ex_aluop,
  input  logic [REG_BUS-1:0]        ex_mem_addr,
  input  logic [REG_BUS-1:0]        ex_reg2,
  input  logic [DOUBLE_REG_BUS-1:0] hilo_i,
  input  logic [1:0]                cnt_i,
  output logic [REG_ADDR_BUS-1:0]   mem_wd,
  output logic                      mem_wreg,
  output logic [REG_BUS-1:0]        mem_wdata,
  output logic                      mem_whilo,
  output logic [REG_BUS-1:0]        mem_hi,
  output logic [REG_BUS-1:0]        mem_lo,
  output logic [ALU_OP_BUS-1:0]     mem_aluop,
  output logic [REG_BUS-1:0]        mem_mem_addr,
  output logic [REG_BUS-1:0]        mem_reg2,
  output logic [DOUBLE_REG_BUS-1:0] hilo_o,
  output logic [1:0]                cnt_o
);

  // Stall handshake: a stage advances only when its stall bit is low.
  // stall[EX_STALL] high with stall[MEM_STALL] low means memory drains
  // while execute repeats, so a NOP bubble must enter memory. Both high
  // means the whole back end freezes.
  stage_act_e act;
  assign act = stage_act(stall);

  // Pipeline register: reset, then flush, then stall-dependent update
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= ZERO_WORD;
      mem_whilo    <= 1'b0;
      mem_hi       <= ZERO_WORD;
      mem_lo       <= ZERO_WORD;
      mem_aluop    <= EXE_NOP_OP;
      mem_mem_addr <= ZERO_WORD;
      mem_reg2     <= ZERO_WORD;
      hilo_o       <= ZERO_DWORD;
      cnt_o        <= 2'b00;
    end else begin
      case (act)
        ACT_BUBBLE: begin
          mem_wd       <= '0;
          mem_wreg     <= 1'b0;
          mem_wdata    <= ZERO_WORD;
          mem_whilo    <= 1'b0;
          mem_hi       <= ZERO_WORD;
          mem_lo       <= ZERO_WORD;
          mem_aluop    <= EXE_NOP_OP;
          mem_mem_addr <= ZERO_WORD;
          mem_reg2     <= ZERO_WORD;
          // partial product and count loop back to execute
          hilo_o       <= hilo_i;
          cnt_o        <= cnt_i;
        end
        ACT_ADVANCE: begin
          mem_wd       <= ex_wd;
          mem_wreg     <= ex_wreg;
          mem_wdata    <= ex_wdata;
          mem_whilo    <= ex_whilo;
          mem_hi       <= ex_hi;
          mem_lo       <= ex_lo;
          mem_aluop    <= ex_aluop;
          mem_mem_addr <= ex_mem_addr;
          mem_reg2     <= ex_reg2;
          // instruction leaves execute: accumulate state is consumed
          hilo_o       <= ZERO_DWORD;
          cnt_o        <= 2'b00;
        end
        default: ; // ACT_HOLD: every register keeps its value
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Bench for the EX/MEM pipeline register: a stimulus table with explicit
// expected key fields, a reference model feeding an expected queue, and a
// few hand-written multi-cycle sequences.
module tb_ex_mem;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } io_t;

  localparam int W = $bits(io_t);

  typedef struct {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] exp_wdata;
    logic [63:0] exp_hilo;
    logic [1:0]  exp_cnt;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic [5:0] stall;
  io_t        drv;

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  io_t act;
  assign act = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
                mem_aluop, mem_mem_addr, mem_reg2, hilo_o, cnt_o};

  ex_mem dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_wd        (drv.wd),
    .ex_wreg      (drv.wreg),
    .ex_wdata     (drv.wdata),
    .ex_whilo     (drv.whilo),
    .ex_hi        (drv.hi),
    .ex_lo        (drv.lo),
    .ex_aluop     (drv.aluop),
    .ex_mem_addr  (drv.addr),
    .ex_reg2      (drv.reg2),
    .hilo_i       (drv.hilo),
    .cnt_i        (drv.cnt),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .hilo_o       (hilo_o),
    .cnt_o        (cnt_o)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  io_t          model_cur;
  int           n_checks = 0;
  int           n_fail   = 0;

  // Reference behaviour of the register for one edge
  function automatic io_t model(io_t cur, logic r, logic f, logic [5:0] s, io_t in);
    io_t n;
    n = '0;
    if (r || f) begin
      n = '0;
    end else if (s[3] && s[4]) begin
      n = cur;
    end else if (s[3]) begin
      n.hilo = in.hilo;
      n.cnt  = in.cnt;
    end else begin
      n = in;
      n.hilo = '0;
      n.cnt  = '0;
    end
    return n;
  endfunction

  function automatic io_t rand_in();
    io_t v;
    v.wd    = 5'($urandom_range(0, 31));
    v.wreg  = 1'($urandom_range(0, 1));
    v.wdata = $urandom;
    v.whilo = 1'($urandom_range(0, 1));
    v.hi    = $urandom;
    v.lo    = $urandom;
    v.aluop = 8'($urandom_range(0, 255));
    v.addr  = $urandom;
    v.reg2  = $urandom;
    v.hilo  = {$urandom, $urandom};
    v.cnt   = 2'($urandom_range(0, 3));
    return v;
  endfunction

  task automatic check_field(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Driver: called at a negedge. Drives one cycle, predicts, waits one
  // edge, then pops and compares the full output word.
  task automatic cycle(input logic r, input logic f, input logic [5:0] s,
                       input io_t in, input string tag, output io_t got);
    io_t e;
    rst   = r;
    flush = f;
    stall = s;
    drv   = in;
    model_cur = model(model_cur, r, f, s, in);
    exp_q.push_back(model_cur);
    @(posedge clk);
    @(negedge clk);
    e   = io_t'(exp_q.pop_front());
    got = act;
    n_checks++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL sb_%s: got %h, expected %h", tag, act, e);
    end
  endtask

  vec_t tbl[18];
  io_t  in_v;
  io_t  got;

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; drv = '0;
    model_cur = '0;

    //        rst   flush stall      wdata         hilo_i                 cnt   exp_wdata     exp_hilo               exp_cnt
    tbl[0]  = '{1'b1, 1'b0, 6'b000000, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 32'h0,        64'h0,                 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 6'b000000, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 32'h0,        64'h0,                 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 6'b000000, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd3, 32'hFFFFFFFF, 64'h0,                 2'd0};
    tbl[3]  = '{1'b0, 1'b0, 6'b000000, 32'h12345678, 64'h5,                 2'd1, 32'h12345678, 64'h0,                 2'd0};
    tbl[4]  = '{1'b0, 1'b0, 6'b001111, 32'h0000AAAA, 64'h1_0000_0002,       2'd1, 32'h0,        64'h1_0000_0002,       2'd1};
    tbl[5]  = '{1'b0, 1'b0, 6'b000000, 32'h0000BEEF, 64'h5,                 2'd2, 32'h0000BEEF, 64'h0,                 2'd0};
    tbl[6]  = '{1'b0, 1'b0, 6'b000000, 32'h11111111, 64'h6,                 2'd0, 32'h11111111, 64'h0,                 2'd0};
    tbl[7]  = '{1'b0, 1'b0, 6'b011111, 32'h22222222, 64'h7,                 2'd3, 32'h11111111, 64'h0,                 2'd0};
    tbl[8]  = '{1'b0, 1'b0, 6'b011111, 32'h23232323, 64'h8,                 2'd1, 32'h11111111, 64'h0,                 2'd0};
    tbl[9]  = '{1'b0, 1'b0, 6'b011111, 32'h24242424, 64'h9,                 2'd2, 32'h11111111, 64'h0,                 2'd0};
    tbl[10] = '{1'b0, 1'b0, 6'b001111, 32'h33333333, 64'hDEAD_0000_BEEF,    2'd2, 32'h0,        64'hDEAD_0000_BEEF,    2'd2};
    tbl[11] = '{1'b0, 1'b0, 6'b011111, 32'h34343434, 64'h1,                 2'd0, 32'h0,        64'hDEAD_0000_BEEF,    2'd2};
    tbl[12] = '{1'b0, 1'b1, 6'b001111, 32'h35353535, 64'h9,                 2'd1, 32'h0,        64'h0,                 2'd0};
    tbl[13] = '{1'b0, 1'b0, 6'b000000, 32'h44444444, 64'h3,                 2'd3, 32'h44444444, 64'h0,                 2'd0};
    tbl[14] = '{1'b0, 1'b0, 6'b010000, 32'h55555555, 64'h4,                 2'd1, 32'h55555555, 64'h0,                 2'd0};
    tbl[15] = '{1'b0, 1'b0, 6'b001111, 32'h66666666, 64'hF0,                2'd3, 32'h0,        64'hF0,                2'd3};
    tbl[16] = '{1'b0, 1'b0, 6'b011111, 32'h77777777, 64'hF1,                2'd0, 32'h0,        64'hF0,                2'd3};
    tbl[17] = '{1'b1, 1'b0, 6'b011111, 32'h88888888, 64'hF2,                2'd1, 32'h0,        64'h0,                 2'd0};

    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 18; i++) begin
      in_v = rand_in();
      if (tbl[i].rst) in_v = '1;
      in_v.wdata = tbl[i].wdata;
      in_v.hilo  = tbl[i].hilo;
      in_v.cnt   = tbl[i].cnt;
      cycle(tbl[i].rst, tbl[i].flush, tbl[i].stall, in_v, $sformatf("row%0d", i), got);
      check_field($sformatf("row%0d_wdata", i), 64'(got.wdata), 64'(tbl[i].exp_wdata));
      check_field($sformatf("row%0d_hilo", i),  got.hilo,        tbl[i].exp_hilo);
      check_field($sformatf("row%0d_cnt", i),   64'(got.cnt),   64'(tbl[i].exp_cnt));
    end

    // normal advance with a specific instruction
    in_v = rand_in();
    in_v.wd = 5'd3; in_v.wreg = 1'b1; in_v.wdata = 32'h1234_5678; in_v.aluop = 8'h25;
    cycle(1'b0, 1'b0, 6'b000000, in_v, "adv", got);
    check_field("adv_wd",    64'(got.wd),    64'd3);
    check_field("adv_wreg",  64'(got.wreg),  64'd1);
    check_field("adv_aluop", 64'(got.aluop), 64'h25);

    // two-cycle multiply-accumulate: stall with product, then release
    in_v = rand_in();
    in_v.hilo = 64'h1_0000_0002; in_v.cnt = 2'd1;
    cycle(1'b0, 1'b0, 6'b001111, in_v, "madd1", got);
    check_field("madd1_wreg", 64'(got.wreg), 64'd0);
    check_field("madd1_cnt",  64'(got.cnt),  64'd1);
    in_v = rand_in();
    in_v.wdata = 32'hCAFE_F00D;
    cycle(1'b0, 1'b0, 6'b000000, in_v, "madd2", got);
    check_field("madd2_wdata", 64'(got.wdata), 64'hCAFE_F00D);
    check_field("madd2_cnt",   64'(got.cnt),   64'd0);

    // back-to-back instructions, no gaps
    for (int k = 1; k <= 4; k++) begin
      in_v = rand_in();
      in_v.wdata = 32'(k);
      cycle(1'b0, 1'b0, 6'b000000, in_v, $sformatf("b2b%0d", k), got);
      check_field($sformatf("b2b%0d_wdata", k), 64'(got.wdata), 64'(k));
    end

    // random soak against the model
    for (int k = 0; k < 200; k++) begin
      logic [5:0] s;
      case ($urandom_range(0, 3))
        0: s = 6'b001111;
        1: s = 6'b011111;
        default: s = 6'b000000;
      endcase
      cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0), s,
            rand_in(), $sformatf("rnd%0d", k), got);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
